// File: rtl/calc_sequencer_if.sv
// Signal bundle between calc_sequencer and the keyboard, assembler, RAM and CPU.
// master is the sequencer side; slave is the surrounding system.
interface calc_sequencer_if;
  logic        go;
  logic [7:0]  operator_code;
  logic [7:0]  operand_1;
  logic [7:0]  operand_2;
  logic        asm_enable;
  logic [15:0] asm_out;
  logic [15:0] asm_addr;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        cpu_reset_n;
  logic        cpu_start;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] result;

  modport master (
    input  go, operator_code, operand_1, operand_2, asm_out, asm_addr, mem_rdata, cpu_halt,
    output asm_enable, mem_we, mem_addr, mem_wdata, cpu_reset_n, cpu_start, busy, done, error, result
  );

  modport slave (
    output go, operator_code, operand_1, operand_2, asm_out, asm_addr, mem_rdata, cpu_halt,
    input  asm_enable, mem_we, mem_addr, mem_wdata, cpu_reset_n, cpu_start, busy, done, error, result
  );
endinterface

// File: rtl/calc_sequencer.sv
// Run sequencer for the keyboard calculator: copies the assembled program into RAM,
// inserts the operands, runs the CPU until halt and captures the result word.
module calc_sequencer #(
  parameter int PROG_LEN = 16,
  parameter int OPA_ADDR = 9,
  parameter int OPB_ADDR = 10,
  parameter int RES_ADDR = 15,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clock,
  input  logic             reset_n,
  calc_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    IDLE, LOAD, WR_A, WR_B, START, WAIT, READ, CAPTURE, DONE, ERROR
  } state_t;

  localparam logic [4:0] LOAD_LAST = 5'(PROG_LEN - 1);
  localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [4:0]  load_cnt_reg, load_cnt_next;
  logic [9:0]  wait_cnt_reg, wait_cnt_next;
  logic [7:0]  opa_reg, opa_next;
  logic [7:0]  opb_reg, opb_next;
  logic [15:0] result_reg, result_next;
  logic        op_valid;
  logic        unused_asm_addr;

  assign op_valid        = (bus.operator_code >= 8'd20) && (bus.operator_code <= 8'd23);
  assign unused_asm_addr = &{1'b0, bus.asm_addr[15:8]};
  assign bus.result      = result_reg;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      load_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      opa_reg      <= '0;
      opb_reg      <= '0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      opa_reg      <= opa_next;
      opb_reg      <= opb_next;
      result_reg   <= result_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    load_cnt_next   = load_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    opa_next        = opa_reg;
    opb_next        = opb_reg;
    result_next     = result_reg;
    bus.asm_enable  = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.cpu_reset_n = 1'b0;
    bus.cpu_start   = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    bus.error       = 1'b0;
    case (state_reg)
      IDLE, DONE, ERROR: begin
        bus.done        = (state_reg == DONE);
        bus.error       = (state_reg == ERROR);
        bus.cpu_reset_n = (state_reg == DONE);
        // Operands are frozen here so keyboard activity mid-run has no effect.
        if (bus.go) begin
          opa_next      = bus.operand_1;
          opb_next      = bus.operand_2;
          load_cnt_next = '0;
          state_next    = op_valid ? LOAD : ERROR;
        end
      end
      LOAD: begin
        bus.asm_enable = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = bus.asm_addr[7:0];
        bus.mem_wdata  = bus.asm_out;
        bus.busy       = 1'b1;
        load_cnt_next  = load_cnt_reg + 5'd1;
        if (load_cnt_reg == LOAD_LAST) state_next = WR_A;
      end
      WR_A: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 8'(OPA_ADDR);
        bus.mem_wdata = {8'h00, opa_reg};
        bus.busy      = 1'b1;
        state_next    = WR_B;
      end
      WR_B: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 8'(OPB_ADDR);
        bus.mem_wdata = {8'h00, opb_reg};
        bus.busy      = 1'b1;
        state_next    = START;
      end
      START: begin
        bus.cpu_reset_n = 1'b1;
        bus.cpu_start   = 1'b1;
        bus.busy        = 1'b1;
        wait_cnt_next   = '0;
        state_next      = WAIT;
      end
      WAIT: begin
        bus.cpu_reset_n = 1'b1;
        bus.busy        = 1'b1;
        wait_cnt_next   = wait_cnt_reg + 10'd1;
        // Halt is checked first so a halt on the last allowed cycle still succeeds.
        if (bus.cpu_halt) state_next = READ;
        else if (wait_cnt_reg == WAIT_LAST) state_next = ERROR;
      end
      READ: begin
        bus.cpu_reset_n = 1'b1;
        bus.busy        = 1'b1;
        bus.mem_addr    = 8'(RES_ADDR);
        state_next      = CAPTURE;
      end
      CAPTURE: begin
        bus.cpu_reset_n = 1'b1;
        bus.busy        = 1'b1;
        result_next     = bus.mem_rdata;
        state_next      = DONE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: assembler, RAM and CPU environment plus a cycle-schedule
// reference model compared against the DUT outputs on every cycle.
module tb_calc_sequencer;
  localparam int TIMEOUT = 1023;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic cmp_en  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  calc_sequencer_if bus();
  calc_sequencer dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Environment: assembler, RAM with registered read, CPU that halts after a delay
  logic [15:0] ram [256];
  logic [15:0] rdata_q    = '0;
  logic [15:0] asm_addr_q = '0;
  logic [7:0]  asm_op     = 8'd20;
  int          halt_delay = 10;
  int          cpu_cnt    = 0;
  logic        cpu_run    = 1'b0;
  logic        halt_q     = 1'b0;

  function automatic logic [15:0] prog_word(input logic [7:0] op, input int idx);
    case (idx)
      0: return 16'h1009;
      1: return 16'h200A;
      2: return {12'h400, 4'(op - 8'd19)};
      3: return 16'h300F;
      4: return 16'h8005;
      default: return 16'hE000 | 16'(idx);
    endcase
  endfunction

  function automatic logic [15:0] cpu_alu(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b);
    case (code)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a * b;
      4'd4: return (b == 16'd0) ? 16'hFFFF : a / b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ref_result(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai = int'(a);
    int bi = int'(b);
    int r = 0;
    case (op)
      8'd20: r = ai + bi;
      8'd21: r = ai - bi;
      8'd22: r = ai * bi;
      default: r = (bi == 0) ? 65535 : ai / bi;
    endcase
    return 16'(r);
  endfunction

  assign bus.asm_addr  = asm_addr_q;
  assign bus.asm_out   = prog_word(asm_op, int'(asm_addr_q[3:0]));
  assign bus.mem_rdata = rdata_q;
  assign bus.cpu_halt  = halt_q;

  initial for (int i = 0; i < 256; i++) ram[i] = '0;

  always @(posedge clock) begin
    asm_addr_q <= bus.asm_enable ? asm_addr_q + 16'd1 : 16'd0;
    if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= ram[bus.mem_addr];
    if (bus.cpu_reset_n !== 1'b1) begin
      cpu_run <= 1'b0;
      cpu_cnt <= 0;
      halt_q  <= 1'b0;
    end else if (bus.cpu_start) begin
      cpu_run <= 1'b1;
      cpu_cnt <= 1;
    end else if (cpu_run) begin
      cpu_cnt <= cpu_cnt + 1;
      if (halt_delay != 0 && cpu_cnt >= halt_delay - 1) begin
        ram[15] <= cpu_alu(ram[2][3:0], ram[9], ram[10]);
        halt_q  <= 1'b1;
        cpu_run <= 1'b0;
      end
    end
  end

  // Reference model: outputs as a function of cycles since the accepted go (k=1 first)
  typedef struct packed {
    logic        asm_enable;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_reset_n;
    logic        cpu_start;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] result;
  } exp_t;

  exp_t        e;
  logic        m_started = 1'b0;
  logic        m_bad     = 1'b0;
  int          m_k       = 0;
  int          m_halt_k  = 0;
  logic [7:0]  m_a = '0, m_b = '0, m_op = 8'd20;
  logic [15:0] m_prev = '0, m_new = '0;

  always_comb begin
    e = '0;
    e.result = m_prev;
    if (m_started) begin
      if (m_bad) e.error = 1'b1;
      else if (m_k <= 16) begin
        e.asm_enable = 1'b1; e.mem_we = 1'b1; e.busy = 1'b1;
        e.mem_addr = 8'(m_k - 1); e.mem_wdata = prog_word(m_op, m_k - 1);
      end else if (m_k == 17) begin
        e.mem_we = 1'b1; e.busy = 1'b1; e.mem_addr = 8'd9; e.mem_wdata = {8'h00, m_a};
      end else if (m_k == 18) begin
        e.mem_we = 1'b1; e.busy = 1'b1; e.mem_addr = 8'd10; e.mem_wdata = {8'h00, m_b};
      end else if (m_k == 19) begin
        e.cpu_start = 1'b1; e.cpu_reset_n = 1'b1; e.busy = 1'b1;
      end else if (m_halt_k == 0) begin
        if (m_k >= 20 + TIMEOUT) e.error = 1'b1;
        else begin e.busy = 1'b1; e.cpu_reset_n = 1'b1; end
      end else if (m_k == m_halt_k + 1) begin
        e.busy = 1'b1; e.cpu_reset_n = 1'b1; e.mem_addr = 8'd15;
      end else if (m_k == m_halt_k + 2) begin
        e.busy = 1'b1; e.cpu_reset_n = 1'b1;
      end else begin
        e.done = 1'b1; e.cpu_reset_n = 1'b1; e.result = m_new;
      end
    end
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      m_started <= 1'b0; m_bad <= 1'b0; m_k <= 0; m_halt_k <= 0; m_prev <= '0;
    end else if (bus.go && !e.busy) begin
      m_started <= 1'b1;
      m_k       <= 1;
      m_halt_k  <= 0;
      m_prev    <= e.result;
      m_bad     <= !(bus.operator_code inside {[8'd20:8'd23]});
      m_a       <= bus.operand_1;
      m_b       <= bus.operand_2;
      m_op      <= bus.operator_code;
      asm_op    <= bus.operator_code;
      m_new     <= ref_result(bus.operator_code, bus.operand_1, bus.operand_2);
    end else if (m_started) begin
      if (m_k < 100000) m_k <= m_k + 1;
      if (!m_bad && m_halt_k == 0 && m_k >= 20 && m_k < 20 + TIMEOUT && bus.cpu_halt)
        m_halt_k <= m_k;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d k=%0d actual=%h expected=%h", name, cyc, m_k, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("asm_enable", 32'(bus.asm_enable), 32'(e.asm_enable));
      chk("mem_we", 32'(bus.mem_we), 32'(e.mem_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e.mem_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.mem_wdata));
      chk("cpu_reset_n", 32'(bus.cpu_reset_n), 32'(e.cpu_reset_n));
      chk("cpu_start", 32'(bus.cpu_start), 32'(e.cpu_start));
      chk("busy", 32'(bus.busy), 32'(e.busy));
      chk("done", 32'(bus.done), 32'(e.done));
      chk("error", 32'(bus.error), 32'(e.error));
      chk("result", 32'(bus.result), 32'(e.result));
    end
  end

  // disturb: 0 none, 1 go pulses at k=5 and k=25 plus operand_1 -> 99, 2 random go/operand noise
  task automatic run(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                     input int delay, input int disturb,
                     output int start_at, output int end_at, output int we_cycles, output logic first_done);
    halt_delay        = delay;
    bus.operator_code = op;
    bus.operand_1     = a;
    bus.operand_2     = b;
    bus.go            = 1'b1;
    @(negedge clock);
    bus.go     = 1'b0;
    start_at   = -1;
    end_at     = -1;
    we_cycles  = 0;
    first_done = bus.done;
    for (int n = 1; n <= 1200; n++) begin
      if (bus.cpu_start && start_at < 0) start_at = n;
      if (bus.mem_we) we_cycles++;
      if (bus.done || bus.error) begin
        end_at = n;
        break;
      end
      bus.go = 1'b0;
      if (disturb == 1 && (n == 5 || n == 25)) bus.go = 1'b1;
      if (disturb == 1 && n == 5) bus.operand_1 = 8'd99;
      if (disturb == 2 && n >= 2 && n <= 18) begin
        bus.go = ($urandom_range(0, 3) == 0);
        bus.operand_1 = 8'($urandom);
        bus.operator_code = 8'($urandom);
      end
      @(negedge clock);
    end
    bus.go = 1'b0;
    if (end_at < 0) begin
      checks++;
      errors++;
      $display("FAIL run_bound no done/error within 1200 cycles op=%0d", op);
    end
  endtask

  initial begin
    int st, en, we;
    logic fd;
    logic [7:0] op, a, b;
    bus.go = 1'b0;
    bus.operator_code = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    cmp_en = 1'b1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);
    chk("reset_result", 32'(bus.result), 32'd0);
    reset_n = 1'b1;

    // Normal add with ignored go pulses and a late operand change
    run(8'd20, 8'd7, 8'd5, 10, 1, st, en, we, fd);
    chk("add_start_cycle", 32'(st), 32'd19);
    chk("add_done_cycle", 32'(en), 32'd32);
    chk("add_done", 32'(bus.done), 32'd1);
    chk("add_result", 32'(bus.result), 32'd12);
    chk("add_we_cycles", 32'(we), 32'd18);
    chk("ram0", 32'(ram[0]), 32'h1009);
    chk("ram1", 32'(ram[1]), 32'h200A);
    chk("ram2", 32'(ram[2]), 32'h4001);
    chk("ram3", 32'(ram[3]), 32'h300F);
    chk("ram4", 32'(ram[4]), 32'h8005);
    chk("ram9", 32'(ram[9]), 32'd7);
    chk("ram10", 32'(ram[10]), 32'd5);
    chk("ram15", 32'(ram[15]), 32'd12);

    // Back-to-back subtract from DONE
    run(8'd21, 8'd9, 8'd4, 6, 0, st, en, we, fd);
    chk("b2b_done_dropped", 32'(fd), 32'd0);
    chk("b2b_result", 32'(bus.result), 32'd5);

    // Invalid operator
    run(8'h30, 8'd1, 8'd2, 10, 0, st, en, we, fd);
    chk("bad_err_cycle", 32'(en), 32'd1);
    chk("bad_error", 32'(bus.error), 32'd1);
    chk("bad_we_cycles", 32'(we), 32'd0);
    chk("bad_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);
    chk("bad_result_held", 32'(bus.result), 32'd5);

    // Timeout: halt never arrives
    run(8'd22, 8'd3, 8'd4, 0, 0, st, en, we, fd);
    chk("to_err_cycle", 32'(en), 32'(20 + TIMEOUT));
    chk("to_error", 32'(bus.error), 32'd1);
    chk("to_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);

    // Halt on the last permitted WAIT cycle still completes
    run(8'd23, 8'd200, 8'd7, TIMEOUT, 0, st, en, we, fd);
    chk("late_halt_cycle", 32'(en), 32'(22 + TIMEOUT));
    chk("late_halt_result", 32'(bus.result), 32'd28);

    // Reset in the middle of LOAD, then a clean run
    bus.operator_code = 8'd20; bus.operand_1 = 8'd7; bus.operand_2 = 8'd5; bus.go = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    for (int n = 1; n < 8; n++) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_asm_enable", 32'(bus.asm_enable), 32'd0);
    chk("rst_mid_result", 32'(bus.result), 32'd0);
    reset_n = 1'b1;
    run(8'd20, 8'd7, 8'd5, 10, 0, st, en, we, fd);
    chk("post_rst_done_cycle", 32'(en), 32'd32);
    chk("post_rst_result", 32'(bus.result), 32'd12);

    // Randomized runs with keyboard noise while busy
    for (int r = 0; r < 25; r++) begin
      op = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(24, 255)) : 8'($urandom_range(20, 23));
      a  = 8'($urandom);
      b  = 8'($urandom);
      run(op, a, b, $urandom_range(2, 60), 2, st, en, we, fd);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
